product_bcd_converter: RTL and testbench



---
 rtl/product_bcd_converter.sv | 92 +++++++++
 tb/tb_product_bcd_converter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Takes the multiplier product and returns a sign flag plus BCD magnitude digits.
module product_bcd_converter #(
  parameter int unsigned W      = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_value,
  input  logic                  in_signed,
  output logic                  out_valid,
  output logic                  out_neg,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [W-1:0]      mag_r;
  logic [BW-1:0]     bcd_r;
  logic              neg_r;
  logic [CW-1:0]     count;

  logic              neg_next;
  logic [W-1:0]      mag_next;
  logic [BW-1:0]     bcd_adj;
  logic [BW+W-1:0]   shift_next;

  // Two's-complement magnitude stays W bits wide, so -2^(W-1) maps to 2^(W-1).
  always_comb begin
    neg_next = in_signed & in_value[W-1];
    mag_next = neg_next ? (~in_value + {{(W-1){1'b0}}, 1'b1}) : in_value;
  end

  always_comb begin
    bcd_adj = bcd_r;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
    end
    shift_next = {bcd_adj, mag_r} << 1;
  end

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mag_r     <= '0;
      bcd_r     <= '0;
      neg_r     <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_neg   <= 1'b0;
      out_bcd   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg_r <= neg_next;
            mag_r <= mag_next;
            bcd_r <= '0;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_r, mag_r} <= shift_next;
          count          <= count + CW'(1);
          if (count == CW'(W - 1))
            state <= DONE;
        end
        DONE: begin
          out_bcd   <= bcd_r;
          out_neg   <= neg_r;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: latency, boundary magnitudes,
// back-to-back acceptance, busy-time requests and asynchronous reset.
module tb_product_bcd_converter;

  localparam int unsigned W      = 16;
  localparam int unsigned DIGITS = 5;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if (pow10(DIGITS) <= (64'd1 << W)) begin : g_digits_check
    $fatal(1, "DIGITS too small for W");
  end

  logic                clk;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_value;
  logic                in_signed;
  logic                out_valid;
  logic                out_neg;
  logic [4*DIGITS-1:0] out_bcd;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  product_bcd_converter #(.W(W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_neg   (out_neg),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with in_ready high; returns at the negedge where out_valid is seen.
  task automatic run_conv(input logic [15:0] v, input logic s,
                          output logic [19:0] bcd, output logic neg, output int lat);
    in_value  = v;
    in_signed = s;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bcd = out_bcd;
    neg = out_neg;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    in_signed = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_neg, out_bcd} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b neg=%b bcd=%h, want 0 0 00000", out_valid, out_neg, out_bcd);
    end
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_ready: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int   lat;
    logic ready_bad;
    in_value  = 16'h3039;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    lat       = 0;
    ready_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ready_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (ready_bad !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy_window: got in_ready high or busy low during conversion, want in_ready=0 busy=1");
    end
    n_cmp++;
    if (lat !== 17) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d, want 17", lat);
    end
    n_cmp++;
    if (out_bcd !== 20'h12345 || out_neg !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_result: got bcd=%h neg=%b, want 12345 0", out_bcd, out_neg);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ready_with_valid: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse_width: got out_valid=%b, want 0", out_valid);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (out_bcd !== 20'h12345) begin
      n_bad++;
      $display("FAIL basic_hold: got bcd=%h, want 12345", out_bcd);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] vin [6];
    logic        sin [6];
    logic [19:0] exp_bcd [6];
    logic        exp_neg [6];
    logic [19:0] bcd;
    logic        neg;
    int          lat;
    vin[0] = 16'h0000; sin[0] = 1'b0; exp_bcd[0] = 20'h00000; exp_neg[0] = 1'b0;
    vin[1] = 16'hFFFF; sin[1] = 1'b0; exp_bcd[1] = 20'h65535; exp_neg[1] = 1'b0;
    vin[2] = 16'hFFFF; sin[2] = 1'b1; exp_bcd[2] = 20'h00001; exp_neg[2] = 1'b1;
    vin[3] = 16'h8000; sin[3] = 1'b1; exp_bcd[3] = 20'h32768; exp_neg[3] = 1'b1;
    vin[4] = 16'h7FFF; sin[4] = 1'b1; exp_bcd[4] = 20'h32767; exp_neg[4] = 1'b0;
    vin[5] = 16'hFF88; sin[5] = 1'b1; exp_bcd[5] = 20'h00120; exp_neg[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_conv(vin[i], sin[i], bcd, neg, lat);
      n_cmp++;
      if (bcd !== exp_bcd[i] || neg !== exp_neg[i] || lat !== 17) begin
        n_bad++;
        $display("FAIL boundary_%0d (in=%h s=%b): got bcd=%h neg=%b lat=%0d, want bcd=%h neg=%b lat=17",
                 i, vin[i], sin[i], bcd, neg, lat, exp_bcd[i], exp_neg[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int          pulses;
    int          t [2];
    logic [19:0] r [2];
    in_value  = 16'd100;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    pulses    = 0;
    t[0] = -1; t[1] = -1;
    r[0] = '0; r[1] = '0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (cyc == 0) in_value = 16'd9999;
      if (pulses == 1 && t[0] == cyc - 1) in_valid = 1'b0;
      if (out_valid) begin
        if (pulses < 2) begin
          t[pulses] = cyc;
          r[pulses] = out_bcd;
        end
        pulses++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (pulses !== 2) begin
      n_bad++;
      $display("FAIL b2b_pulse_count: got %0d, want 2", pulses);
    end
    n_cmp++;
    if (r[0] !== 20'h00100 || r[1] !== 20'h09999) begin
      n_bad++;
      $display("FAIL b2b_results: got %h then %h, want 00100 then 09999", r[0], r[1]);
    end
    n_cmp++;
    if (t[0] !== 17 || t[1] - t[0] !== 18) begin
      n_bad++;
      $display("FAIL b2b_spacing: got first=%0d gap=%0d, want first=17 gap=18", t[0], t[1] - t[0]);
    end
  endtask

  task automatic test_ignore_busy();
    int          lat;
    logic [19:0] bcd;
    logic        neg;
    in_value  = 16'd42;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        in_value = 16'd7;
        in_valid = 1'b1;
      end
      if (lat == 6) in_valid = 1'b0;
    end
    n_cmp++;
    if (out_bcd !== 20'h00042 || lat !== 17) begin
      n_bad++;
      $display("FAIL ignore_busy: got bcd=%h lat=%0d, want 00042 lat=17", out_bcd, lat);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_no_queue: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    run_conv(16'd7, 1'b0, bcd, neg, lat);
    n_cmp++;
    if (bcd !== 20'h00007 || neg !== 1'b0 || lat !== 17) begin
      n_bad++;
      $display("FAIL ignore_later_accept: got bcd=%h neg=%b lat=%0d, want 00007 0 17", bcd, neg, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int          seen;
    int          lat;
    logic [19:0] bcd;
    logic        neg;
    in_value  = 16'd1234;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_neg, out_bcd} !== 22'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_async: got valid=%b neg=%b bcd=%h ready=%b busy=%b, want 0 0 00000 1 0",
               out_valid, out_neg, out_bcd, in_ready, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL midreset_no_valid: got %0d pulses, want 0", seen);
    end
    run_conv(16'd500, 1'b0, bcd, neg, lat);
    n_cmp++;
    if (bcd !== 20'h00500 || neg !== 1'b0 || lat !== 17) begin
      n_bad++;
      $display("FAIL midreset_recover: got bcd=%h neg=%b lat=%0d, want 00500 0 17", bcd, neg, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
